// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 device-side transmitter bank.
//   ps2_state_t     : per-channel frame state (IDLE, DATA, PARITY, STOP, DONE)
//   PS2_FRAME_TICKS : ticks from start-bit drive back to IDLE
//   PS2_DATA_BITS   : payload bits per frame
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } ps2_state_t;

  localparam int unsigned PS2_FRAME_TICKS = 12;
  localparam int unsigned PS2_DATA_BITS   = 8;

endpackage

// File: rtl/ps2_tx_chan.sv
// ps2_tx_chan: one PS/2 device-to-host channel, i.e. a byte FIFO feeding an
// 11-bit frame serialiser (start, 8 data LSB first, odd parity, stop).
// Optional macro: PS2_INHIBIT_EN enables host-inhibit abort/retransmit.
// Ports:
//   clk_sys, reset_n : system clock, synchronous active-low reset
//   tick, phase      : shared divider outputs (tick = PS/2 rising edge pulse)
//   wr_en, wr_data   : enqueue request already decoded for this channel
//   ps2_clk_in       : sampled bus clock level (inhibit detection only)
//   fifo_full        : FIFO holds 2**FIFO_BITS bytes
//   overflow         : sticky, a write was dropped because the FIFO was full
//   ps2_clk/ps2_data : emulated bus outputs, both 1 when idle
module ps2_tx_chan
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       phase,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ps2_clk_in,
  output logic       fifo_full,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int unsigned DEPTH = 2 ** FIFO_BITS;
  localparam int unsigned BC_W  = $clog2(PS2_DATA_BITS);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PS2_DATA_BITS - 1);

  logic [7:0]       mem [DEPTH];
  logic [FIFO_BITS:0] wr_ptr;
  logic [FIFO_BITS:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             abort;
  logic             start_ok;

  ps2_state_t       state;
  logic [7:0]       shift;
  logic             parity;
  logic [BC_W-1:0]  bit_cnt;

  // Extra pointer MSB distinguishes full from empty so every slot is usable.
  assign full  = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
                 (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = wr_en && !full;
  assign pop   = tick && (state == ST_DONE) && !abort;

  assign fifo_full = full;
  assign ps2_clk   = phase | (state == ST_IDLE);

`ifdef PS2_INHIBIT_EN
  // Host pulling the clock low while we release it means inhibit.
  assign abort    = (state != ST_IDLE) && ps2_clk && !ps2_clk_in;
  assign start_ok = ps2_clk_in;
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign abort    = 1'b0;
  assign start_ok = 1'b1;
`endif

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr[FIFO_BITS-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Head byte stays in the FIFO until DONE so an aborted frame is resent.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ps2_data <= 1'b1;
      shift    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      ps2_data <= 1'b1;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!empty && start_ok) begin
            shift    <= mem[rd_ptr[FIFO_BITS-1:0]];
            parity   <= 1'b1;
            ps2_data <= 1'b0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          ps2_data <= shift[0];
          shift    <= shift >> 1;
          parity   <= parity ^ shift[0];
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          ps2_data <= parity;
          state    <= ST_STOP;
        end
        ST_STOP: begin
          ps2_data <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_tx_bank.sv
// ps2_tx_bank: multi-channel PS/2 device emulator. Bytes from the command
// decoder are queued per channel and sent as 11-bit device-to-host frames.
// Optional macro: PS2_INHIBIT_EN (host-inhibit abort and retransmit).
// Ports:
//   clk_sys, reset_n           : system clock, synchronous active-low reset
//   wr_data, wr_chan, wr_strobe: one-cycle enqueue of a byte to a channel;
//                                channels >= CHANNELS are ignored
//   fifo_full, overflow        : per-channel FIFO full / sticky drop flag
//   ps2_clk_in                 : sampled bus clock (inhibit build only)
//   ps2_clk, ps2_data          : per-channel emulated bus, idle high
module ps2_tx_bank
  import ps2_pkg::*;
#(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned CH_BITS   = 1,
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned PS2DIV    = 100
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [7:0]          wr_data,
  input  logic [CH_BITS-1:0]  wr_chan,
  input  logic                wr_strobe,
  output logic [CHANNELS-1:0] fifo_full,
  output logic [CHANNELS-1:0] overflow,
  input  logic [CHANNELS-1:0] ps2_clk_in,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data
);

  localparam int unsigned CNT_W = $clog2(PS2DIV + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PS2DIV);

  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             tick;

  // tick is registered, so channel data moves one cycle after ps2_clk rises.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
        tick  <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [CH_BITS-1:0] CH_ID = CH_BITS'(i);
    logic wr_en;
    assign wr_en = wr_strobe && (wr_chan == CH_ID);

    ps2_tx_chan #(
      .FIFO_BITS (FIFO_BITS)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tick       (tick),
      .phase      (phase),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .ps2_clk_in (ps2_clk_in[i]),
      .fifo_full  (fifo_full[i]),
      .overflow   (overflow[i]),
      .ps2_clk    (ps2_clk[i]),
      .ps2_data   (ps2_data[i])
    );
  end

endmodule
